// File: rtl/mxv_pkg.sv
// Shared types and helpers for the matrix-vector multiply sequencer.
package mxv_pkg;

    localparam int unsigned MXV_MAX_DIM = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mxv_state_e;

    // Smallest width able to hold v distinct codes; never below 1 bit.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mxv_idx_counter.sv
// Index counter with sync clear, enable and a runtime wrap value; wrap_c_o flags the wrapping beat.
module mxv_idx_counter
    import mxv_pkg::*;
#(
    parameter int unsigned CNT_BITS  = 4,
    parameter int unsigned LAST_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [LAST_BITS-1:0] last_i,
    output logic [CNT_BITS-1:0]  cnt_o,
    output logic                 wrap_c_o
);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Compare in the wider dimension domain so the count never runs past last_i.
    assign wrap_c_o = en_i && (LAST_BITS'(cnt_q) == last_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_c_o ? '0 : CNT_BITS'(cnt_q + CNT_BITS'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mxv_sequencer.sv
// Row/column sequencer for an N x N matrix times N-vector MAC datapath.
// Optional start-time dimension check enabled by defining MXV_SEQ_DIM_CHECK_EN.
module mxv_sequencer
    import mxv_pkg::*;
#(
    parameter int unsigned MAX_DIM  = MXV_MAX_DIM,
    parameter int unsigned DIM_BITS = ceil_log2(MAX_DIM + 1),
    parameter int unsigned IDX_BITS = ceil_log2(MAX_DIM)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DIM_BITS-1:0] dim,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [IDX_BITS-1:0] row_idx,
    output logic [IDX_BITS-1:0] col_idx,
    output logic                mac_en,
    output logic                acc_clr,
    output logic                result_we,
    output logic                busy,
    output logic                done,
    output logic                err
);

    mxv_state_e          state_q, state_d;
    logic [DIM_BITS-1:0] dim_q, dim_d, last_idx;
    logic                err_q, err_d;
    logic                cnt_clr, col_en, row_en, col_wrap, row_wrap, dim_bad;

    assign last_idx = DIM_BITS'(dim_q - DIM_BITS'(1));
    assign col_en   = (state_q == ST_RUN) && in_valid;
    assign row_en   = (state_q == ST_WRITE);

`ifdef MXV_SEQ_DIM_CHECK_EN
    assign dim_bad = (dim == '0) || (dim > DIM_BITS'(MAX_DIM));
`else
    assign dim_bad = 1'b0;
`endif

    mxv_idx_counter #(.CNT_BITS(IDX_BITS), .LAST_BITS(DIM_BITS)) u_col_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .en_i     (col_en),
        .last_i   (last_idx),
        .cnt_o    (col_idx),
        .wrap_c_o (col_wrap)
    );

    mxv_idx_counter #(.CNT_BITS(IDX_BITS), .LAST_BITS(DIM_BITS)) u_row_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .en_i     (row_en),
        .last_i   (last_idx),
        .cnt_o    (row_idx),
        .wrap_c_o (row_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dim_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dim_q   <= dim_d;
            err_q   <= err_d;
        end
    end

    // Next state plus state-decoded strobes.
    always_comb begin
        state_d   = state_q;
        dim_d     = dim_q;
        err_d     = 1'b0;
        cnt_clr   = 1'b0;
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        acc_clr   = 1'b0;
        result_we = 1'b0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        err       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dim_bad) begin
                        err_d = 1'b1;
                    end else begin
                        dim_d   = dim;
                        cnt_clr = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                acc_clr = 1'b1;
                state_d = (dim_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                mac_en   = col_en;
                if (col_wrap) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                result_we = 1'b1;
                acc_clr   = 1'b1;
                state_d   = row_wrap ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done    = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Scoreboard bench for mxv_sequencer: expected rows and done times are queued at stimulus time.
module tb_mxv_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [4:0] dim;
    logic       in_ready, mac_en, acc_clr, result_we, busy, done, err;
    logic [3:0] row_idx, col_idx;

    mxv_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dim       (dim),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .mac_en    (mac_en),
        .acc_clr   (acc_clr),
        .result_we (result_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         row_q[$];
    int         done_q[$];
    int         cur_dim, exp_col, mac_cnt, we_cnt, done_cnt, err_cnt;
    bit         prev_wait;
    logic [3:0] prev_col;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        int e;
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            chk("mac_en", int'(mac_en), int'(in_ready & in_valid));
            if (done) chk("done_exclusive", int'(mac_en | result_we | acc_clr), 0);
            if (mac_en) begin
                chk("col_idx", int'(col_idx), exp_col);
                exp_col = (exp_col == cur_dim - 1) ? 0 : exp_col + 1;
                mac_cnt++;
            end
            if (prev_wait && in_ready) chk("col_hold", int'(col_idx), int'(prev_col));
            prev_wait = in_ready && !in_valid;
            prev_col  = col_idx;
            if (result_we) begin
                if (row_q.size() == 0) begin
                    fail_msg("unexpected result_we");
                end else begin
                    e = row_q.pop_front();
                    chk("result_row", int'(row_idx), e);
                end
                chk("we_acc_clr", int'(acc_clr), 1);
                we_cnt++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_msg("unexpected done");
                end else begin
                    e = done_q.pop_front();
                    if (e >= 0) chk("done_cycle", cyc, e);
                end
                done_cnt++;
            end
            if (err) err_cnt++;
        end
    end

    task automatic clear_counts(input int n);
        cur_dim  = n;
        exp_col  = 0;
        mac_cnt  = 0;
        we_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // One multiply; lat < 0 means the done time is not checked.
    task automatic run(input int n, input bit toggle, input bit poke_start, input int lat);
        clear_counts(n);
        for (int r = 0; r < n; r++) row_q.push_back(r);
        done_q.push_back(lat < 0 ? -1 : cyc + lat);
        start    = 1'b1;
        dim      = 5'(n);
        in_valid = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
            if (poke_start) begin
                start = (k == 3);
                dim   = (k == 3) ? 5'd3 : 5'(n);
            end
            if (toggle) in_valid = ~in_valid;
            step();
        end
        start = 1'b0;
        if (done_cnt == 0) fail_msg("done timeout");
        step();
        step();
        chk("mac_count", mac_cnt, n * n);
        chk("we_count", we_cnt, n);
        chk("done_count", done_cnt, 1);
        chk("rows_left", row_q.size(), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_strobes"}, int'({in_ready, mac_en, acc_clr, result_we}), 0);
        chk({tag, "_row"}, int'(row_idx), 0);
        chk({tag, "_col"}, int'(col_idx), 0);
    endtask

    task automatic reset_mid_run();
        bit hit;
        clear_counts(4);
        for (int r = 0; r < 4; r++) row_q.push_back(r);
        start    = 1'b1;
        dim      = 5'd4;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (row_idx == 4'd2 && col_idx == 4'd1) hit = 1'b1;
            else step();
        end
        if (!hit) fail_msg("row2 col1 never reached");
        chk("we_before_reset", we_cnt, 2);
        reset = 1'b1;
        step();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        row_q.delete();
        done_q.delete();
        step();
        check_idle_outputs("post_reset");
    endtask

`ifdef MXV_SEQ_DIM_CHECK_EN
    task automatic err_case(input int n);
        clear_counts(n);
        start = 1'b1;
        dim   = 5'(n);
        step();
        start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        step();
        chk("err_clear", int'(err), 0);
        chk("err_busy2", int'(busy), 0);
        step();
        chk("err_count", err_cnt, 1);
        chk("err_no_done", done_cnt, 0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        dim      = 5'd4;
        in_valid = 1'b0;
        clear_counts(0);
        prev_wait = 1'b0;
        prev_col  = '0;
        step();
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;
        start = 1'b0;
        step();
        check_idle_outputs("after_reset");

        run(4, 1'b0, 1'b0, 22);
        run(1, 1'b0, 1'b0, 4);
        run(3, 1'b1, 1'b0, -1);
        run(2, 1'b0, 1'b1, 8);
        run(16, 1'b0, 1'b0, 274);
        reset_mid_run();
        run(2, 1'b0, 1'b0, 8);
`ifdef MXV_SEQ_DIM_CHECK_EN
        err_case(0);
        err_case(17);
`else
        run(0, 1'b0, 1'b0, 2);
`endif
        run(3, 1'b0, 1'b0, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
